sram_controller: RTL and testbench

Memory-side responder for the pipeline's MEM stage. It accepts a single 32-bit read or write request, which is held stable by the MEM stage while `ready` is low. It performs the access on an external 16-bit asynchronous SRAM as two halfword transactions and returns read data. `ready` feeds the pipeline freeze logic, so the whole pipeline stalls until the access completes.

---
 rtl/sram_controller.sv | 169 ++++++++++++++++
 tb/tb_sram_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller
//   Turns one 32-bit load/store request from the MEM stage into two 16-bit
//   transactions on an external asynchronous SRAM. The low halfword is
//   accessed first, then the high halfword. `ready` is low while the access
//   is in progress, which freezes the pipeline.
//
// Parameters
//   BASE_ADDR     : CPU byte address that maps to SRAM halfword 0
//   ACCESS_CYCLES : clock cycles per halfword transaction (2..15)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   mem_read, mem_write : request strobes, held by the requester until ready
//   address, data       : CPU byte address and store data
//   read_data           : registered load result, held between reads
//   ready               : combinational; high when idle or in the final cycle
//   sram_addr           : registered SRAM halfword address
//   sram_dq_out/_in     : SRAM data bus, write and read directions
//   sram_dq_oe          : drive enable for sram_dq_out
//   sram_ce_n/oe_n/we_n : active-low SRAM strobes, all registered
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] data_q, data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [31:0] read_data_q, read_data_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic        active_d;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req    = mem_read | mem_write;
  assign offset = address - BASE;
  // Byte-within-word bits and bits beyond the SRAM's reach do not select anything.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Combinational so the pipeline freezes in the very cycle a request appears.
  assign ready = ~req | (state_q == DONE);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    data_d      = data_q;
    sram_addr_d = sram_addr_q;
    read_data_d = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read and write is treated as a write.
          is_write_d  = mem_write;
          sram_addr_d = {offset[18:2], 1'b0};
          data_d      = data;
          cnt_d       = '0;
          state_d     = LO;
        end
      end
      LO: begin
        if (cnt_q == LAST_CNT) begin
          if (!is_write_q) read_data_d[15:0] = sram_dq_in;
          sram_addr_d = sram_addr_q + 18'd1;
          cnt_d       = '0;
          state_d     = HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST_CNT) begin
          if (!is_write_q) read_data_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // Always go back to IDLE so a request still held is not re-issued.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so they are derived from the next-cycle state
    // and phase count and appear in the same cycle as the state they belong to.
    active_d = (state_d == LO) || (state_d == HI);
    ce_n_d   = ~active_d;
    oe_n_d   = ~(active_d & ~is_write_d);
    dq_oe_d  = active_d & is_write_d;
    // Write enable is released in the last phase cycle to give address/data hold.
    we_n_d   = ~(active_d & is_write_d & (cnt_d != LAST_CNT));
    dq_out_d = '0;
    if (active_d && is_write_d) begin
      dq_out_d = (state_d == HI) ? data_d[31:16] : data_d[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      data_q      <= '0;
      sram_addr_q <= '0;
      read_data_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      data_q      <= data_d;
      sram_addr_q <= sram_addr_d;
      read_data_q <= read_data_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Directed bench for sram_controller. Two instances share the request
//   inputs: `dut` uses ACCESS_CYCLES=2 and `dut3` uses ACCESS_CYCLES=3. Each
//   instance has its own behavioural SRAM model. Outputs are sampled 1 ns
//   after the falling clock edge; inputs change on the falling edge.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] data;

  logic [31:0] read_data,   read_data3;
  logic        ready,       ready3;
  logic [17:0] sram_addr,   sram_addr3;
  logic [15:0] sram_dq_out, sram_dq_out3;
  logic [15:0] sram_dq_in,  sram_dq_in3;
  logic        sram_dq_oe,  sram_dq_oe3;
  logic        sram_ce_n,   sram_ce_n3;
  logic        sram_oe_n,   sram_oe_n3;
  logic        sram_we_n,   sram_we_n3;

  logic [15:0] mem  [0:255];
  logic [15:0] mem3 [0:255];
  int          we_even = 0;
  int          we_odd  = 0;

  int total = 0;
  int bad   = 0;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data(data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data(data), .read_data(read_data3), .ready(ready3),
    .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_in(sram_dq_in3),
    .sram_dq_oe(sram_dq_oe3), .sram_ce_n(sram_ce_n3), .sram_oe_n(sram_oe_n3),
    .sram_we_n(sram_we_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: reads are combinational while selected and output-enabled;
  // a write lands on each clock edge where CE, WE and the bus driver are active.
  assign sram_dq_in  = (!sram_ce_n  && !sram_oe_n)  ? mem[sram_addr[7:0]]   : 16'hxxxx;
  assign sram_dq_in3 = (!sram_ce_n3 && !sram_oe_n3) ? mem3[sram_addr3[7:0]] : 16'hxxxx;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      if (sram_addr[0]) we_odd  <= we_odd + 1;
      else              we_even <= we_even + 1;
    end
    if (!sram_ce_n3 && !sram_we_n3 && sram_dq_oe3) mem3[sram_addr3[7:0]] <= sram_dq_out3;
  end

  // Drives a request and steps one cycle at a time until the selected
  // instance raises ready. done_cyc is the cycle index (request first seen
  // in cycle 0) at which ready rose, or -1 on timeout. The request is left
  // held; the caller is in the DONE cycle on return.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] dat, input bit on3, input bit skip_first,
                            output int done_cyc, output logic [3:0] c1_strb,
                            output logic [17:0] c1_addr, output logic [17:0] hi_addr);
    int a;
    a         = on3 ? 3 : 2;
    mem_write = wr;
    mem_read  = rd;
    address   = addr;
    data      = dat;
    if (skip_first) @(negedge clk);
    #1;
    done_cyc = -1;
    c1_strb  = '1;
    c1_addr  = '0;
    hi_addr  = '0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 1) begin
        c1_strb = on3 ? {sram_ce_n3, sram_oe_n3, sram_we_n3, sram_dq_oe3}
                      : {sram_ce_n,  sram_oe_n,  sram_we_n,  sram_dq_oe};
        c1_addr = on3 ? sram_addr3 : sram_addr;
      end
      if (c == a + 1) hi_addr = on3 ? sram_addr3 : sram_addr;
      if (on3 ? ready3 : ready) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drop_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_strobes_in_reset: got %b want 1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 5'b11110) begin
        bad++;
        $display("FAIL idle_outputs[%0d]: got %b want 11110", i,
                 {ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
      end
      total++;
      if (read_data !== 32'h0) begin
        bad++;
        $display("FAIL idle_read_data[%0d]: got %h want 00000000", i, read_data);
      end
    end
  endtask

  task automatic test_write();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    int e0, o0;
    e0 = we_even;
    o0 = we_odd;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (d !== 5) begin bad++; $display("FAIL write_latency: got %0d want 5", d); end
    total++;
    if (s !== 4'b0101) begin bad++; $display("FAIL write_strobes_lo: got %b want 0101", s); end
    total++;
    if (read_data !== 32'h0) begin bad++; $display("FAIL write_keeps_read_data: got %h want 00000000", read_data); end
    drop_req();
    total++;
    if (mem[0] !== 16'hBEEF) begin bad++; $display("FAIL write_hw0: got %h want beef", mem[0]); end
    total++;
    if (mem[1] !== 16'hDEAD) begin bad++; $display("FAIL write_hw1: got %h want dead", mem[1]); end
    total++;
    if ((we_even - e0) !== 1 || (we_odd - o0) !== 1) begin
      bad++;
      $display("FAIL write_we_cycles: got lo=%0d hi=%0d want 1 1", we_even - e0, we_odd - o0);
    end
  endtask

  task automatic test_read_back();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    int e0, o0;
    e0 = we_even;
    o0 = we_odd;
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (d !== 5) begin bad++; $display("FAIL read_latency: got %0d want 5", d); end
    total++;
    if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data: got %h want deadbeef", read_data); end
    total++;
    if (s !== 4'b0010) begin bad++; $display("FAIL read_strobes_lo: got %b want 0010", s); end
    total++;
    if (a1 !== 18'd0 || a2 !== 18'd1) begin bad++; $display("FAIL read_addrs: got %0d %0d want 0 1", a1, a2); end
    drop_req();
    total++;
    if ((we_even - e0) !== 0 || (we_odd - o0) !== 0) begin
      bad++;
      $display("FAIL read_no_we: got lo=%0d hi=%0d want 0 0", we_even - e0, we_odd - o0);
    end
  endtask

  task automatic test_mapping();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    run_access(1'b1, 1'b0, 32'd1031, 32'h12345678, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (a1 !== 18'd2 || a2 !== 18'd3) begin bad++; $display("FAIL map_addrs: got %0d %0d want 2 3", a1, a2); end
    drop_req();
    total++;
    if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
      bad++;
      $display("FAIL map_halfwords: got %h %h want 5678 1234", mem[2], mem[3]);
    end
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (read_data !== 32'h12345678) begin bad++; $display("FAIL map_read: got %h want 12345678", read_data); end
    drop_req();
  endtask

  task automatic test_both();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    run_access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (s !== 4'b0101) begin bad++; $display("FAIL both_is_write: got %b want 0101", s); end
    total++;
    if (read_data !== 32'h12345678) begin bad++; $display("FAIL both_keeps_read_data: got %h want 12345678", read_data); end
    drop_req();
    total++;
    if (mem[0] !== 16'hF00D || mem[1] !== 16'hCAFE) begin
      bad++;
      $display("FAIL both_halfwords: got %h %h want f00d cafe", mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    mem_read = 1'b1;
    address  = 32'd1024;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if ({sram_ce_n, sram_oe_n, sram_addr} !== {2'b00, 18'd1}) begin
      bad++;
      $display("FAIL midread_in_hi: got ce=%b oe=%b addr=%0d want 0 0 1", sram_ce_n, sram_oe_n, sram_addr);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      bad++;
      $display("FAIL midread_strobes: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    total++;
    if (read_data !== 32'h0) begin bad++; $display("FAIL midread_read_data: got %h want 00000000", read_data); end
    total++;
    if (ready !== 1'b0 || sram_addr !== 18'd0) begin
      bad++;
      $display("FAIL midread_idle: got ready=%b addr=%0d want 0 0", ready, sram_addr);
    end
    @(negedge clk);
    mem_read = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    #1;
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0, d, s, a1, a2);
    total++;
    if (d !== 5) begin bad++; $display("FAIL after_reset_latency: got %0d want 5", d); end
    total++;
    if (read_data !== 32'hCAFEF00D) begin bad++; $display("FAIL after_reset_read: got %h want cafef00d", read_data); end
    drop_req();
  endtask

  task automatic test_back_to_back();
    int d;
    logic [3:0]  s;
    logic [17:0] a1, a2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'd1032, 32'hA5A55A5A, 1'b1, 1'b0, d, s, a1, a2);
    total++;
    if (d !== 7) begin bad++; $display("FAIL b2b_write_latency: got %0d want 7", d); end
    total++;
    if (a1 !== 18'd4 || a2 !== 18'd5) begin bad++; $display("FAIL b2b_write_addrs: got %0d %0d want 4 5", a1, a2); end
    // Switch to the read while still in DONE; the next cycle is the IDLE cycle 0.
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1, 1'b1, d, s, a1, a2);
    total++;
    if (d !== 7) begin bad++; $display("FAIL b2b_read_latency: got %0d want 7", d); end
    total++;
    if (read_data3 !== 32'hA5A55A5A) begin bad++; $display("FAIL b2b_read_data: got %h want a5a55a5a", read_data3); end
    drop_req();
    total++;
    if (mem3[4] !== 16'h5A5A || mem3[5] !== 16'hA5A5) begin
      bad++;
      $display("FAIL b2b_halfwords: got %h %h want 5a5a a5a5", mem3[4], mem3[5]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = 32'h0;
    data      = 32'h0;
    test_reset();
    test_write();
    test_read_back();
    test_mapping();
    test_both();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
